// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) / S-box helpers for the iterative AES-128 decrypter.
// S-boxes are computed arithmetically (inverse in GF(2^8) plus affine map) rather than tabulated.
package aes_dec_pkg;

  typedef logic [2:0] fsm_t;
  localparam fsm_t KEY_IDLE = 3'd0;
  localparam fsm_t KEY_EXP  = 3'd1;
  localparam fsm_t IDLE     = 3'd2;
  localparam fsm_t ROUND    = 3'd3;
  localparam fsm_t DONE     = 3'd4;

  // Indexed by key-expansion step 1..10; entry 0 is never used.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // [column][row]; byte n of a block lives at [n/4][n%4], byte 0 = bits 127:120.
  typedef logic [7:0] aes_state_t [4][4];

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_mul2(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic aes_state_t blk_to_state(input logic [127:0] b);
    aes_state_t s;
    for (int n = 0; n < 16; n++) s[n / 4][n % 4] = b[127 - 8 * n -: 8];
    return s;
  endfunction

  function automatic logic [127:0] state_to_blk(input aes_state_t s);
    logic [127:0] b;
    for (int n = 0; n < 16; n++) b[127 - 8 * n -: 8] = s[n / 4][n % 4];
    return b;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, combinational: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_round is set.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] nxt
);

  aes_state_t   s_in, s_sub, s_add, s_mix;
  logic [127:0] added;

  // NOTE: always_comb uses blocking assignments and gives every variable a value on every
  // pass, which is what keeps latches from being inferred.
  always_comb begin
    s_in = blk_to_state(st);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s_sub[c][r] = inv_sbox(s_in[(c + 4 - r) % 4][r]);
    added = state_to_blk(s_sub) ^ rk;
    s_add = blk_to_state(added);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s_mix[c][r] = gf_mul(s_add[c][r], 8'h0e)           ^ gf_mul(s_add[c][(r + 1) % 4], 8'h0b) ^
                      gf_mul(s_add[c][(r + 2) % 4], 8'h0d) ^ gf_mul(s_add[c][(r + 3) % 4], 8'h09);
    nxt = last_round ? added : state_to_blk(s_mix);
  end

endmodule

// File: rtl/aes_decrypter_iter.sv
// Iterative AES-128 decrypter: one-time key expansion into 11 round keys, then one round per clock.
// Optional AES_DEC_PERF_CNT_EN adds a wrapping blocks_done handshake counter.
module aes_decrypter_iter
  import aes_dec_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int NR       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [127:0]        data_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [127:0]        data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                key_loaded
`ifdef AES_DEC_PERF_CNT_EN
  ,
  output logic [31:0]         blocks_done
`endif
);

  localparam logic [3:0] LAST_K = 4'(NR);

  fsm_t          state, state_nxt;
  logic [3:0]    kcnt, rcnt;
  logic [127:0]  st, round_out;
  logic [127:0]  rk [0:NR];
  logic [127:0]  prev_rk, next_rk;
  logic [31:0]   tmp;
  logic          key_hs, in_hs;

  // A key offered in IDLE takes priority over data in the same cycle.
  assign in_ready = (state == IDLE) && !key_valid;
  assign key_hs   = key_valid && key_ready;
  assign in_hs    = in_valid && in_ready;

  aes_inv_round u_round (
    .st         (st),
    .rk         (rk[rcnt]),
    .last_round (rcnt == 4'd0),
    .nxt        (round_out)
  );

  always_comb begin
    prev_rk = rk[kcnt - 4'd1];
    tmp     = {sbox(prev_rk[23:16]), sbox(prev_rk[15:8]), sbox(prev_rk[7:0]), sbox(prev_rk[31:24])}
              ^ {RCON[kcnt], 24'h0};
    next_rk[127:96] = prev_rk[127:96] ^ tmp;
    next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
    next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
    next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      KEY_IDLE: if (key_hs) state_nxt = KEY_EXP;
      KEY_EXP:  if (kcnt == LAST_K) state_nxt = IDLE;
      IDLE: begin
        if (key_hs)     state_nxt = KEY_EXP;
        else if (in_hs) state_nxt = ROUND;
      end
      ROUND:    if (rcnt == 4'd0) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = KEY_IDLE;
    endcase
  end

  // NOTE: the round-key file is cleared by reset so a reset genuinely discards the key;
  // this costs a reset on every flop of the file rather than plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= KEY_IDLE;
      kcnt       <= '0;
      rcnt       <= '0;
      st         <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      key_loaded <= 1'b0;
      key_ready  <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state     <= state_nxt;
      key_ready <= (state_nxt == KEY_IDLE) || (state_nxt == IDLE);
      case (state)
        KEY_IDLE: if (key_hs) begin
          rk[0] <= key;
          kcnt  <= 4'd1;
        end
        KEY_EXP: begin
          rk[kcnt] <= next_rk;
          kcnt     <= kcnt + 4'd1;
          if (kcnt == LAST_K) key_loaded <= 1'b1;
        end
        IDLE: begin
          if (key_hs) begin
            key_loaded <= 1'b0;
            rk[0]      <= key;
            kcnt       <= 4'd1;
          end else if (in_hs) begin
            st   <= data_in ^ rk[NR];
            rcnt <= 4'(NR - 1);
          end
        end
        ROUND: begin
          if (rcnt == 4'd0) begin
            data_out  <= round_out;
            out_valid <= 1'b1;
          end else begin
            st   <= round_out;
            rcnt <= rcnt - 4'd1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef AES_DEC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      blocks_done <= '0;
    else if (out_valid && out_ready) blocks_done <= blocks_done + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_decrypter_iter.sv
// Self-checking bench for aes_decrypter_iter: FIPS-197 vectors plus random blocks whose
// ciphertext comes from a forward AES-128 encryption model built from first principles.
module tb_aes_decrypter_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key, data_in, data_out;
  logic         key_valid, key_ready, in_valid, in_ready, out_valid, out_ready, key_loaded;
`ifdef AES_DEC_PERF_CNT_EN
  logic [31:0]  blocks_done;
`endif

  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           n_blocks = 0;
  logic [7:0]   sb [256];

  aes_decrypter_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .key_loaded (key_loaded)
`ifdef AES_DEC_PERF_CNT_EN
    ,
    .blocks_done(blocks_done)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256 && x != 0; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t32;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t32 = w[i - 1];
      if (i % 4 == 0) begin
        t32 = {sb[t32[23:16]], sb[t32[15:8]], sb[t32[7:0]], sb[t32[31:24]]} ^ {rc, 24'h0};
        rc  = m_mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t32;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8 * n -: 8] ^ w[n / 4][31 - 8 * (n % 4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4 * c + 3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4 * rnd + n / 4][31 - 8 * (n % 4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127 - 8 * n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after the key-accept edge: 10 expansion cycles with key_ready low.
  task automatic expect_expansion(input string tag);
    for (int i = 0; i < 10; i++) begin
      check({tag, "_kexp_key_ready"}, key_ready, 1'b0);
      check({tag, "_kexp_loaded"}, key_loaded, 1'b0);
      tick();
    end
    check({tag, "_key_loaded_rise"}, key_loaded, 1'b1);
    check({tag, "_key_ready_idle"}, key_ready, 1'b1);
  endtask

  task automatic load_key(input logic [127:0] k, input string tag);
    int w;
    w = 0;
    while (!key_ready && w < 40) begin tick(); w++; end
    check({tag, "_key_ready_wait"}, key_ready, 1'b1);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    expect_expansion(tag);
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp_pt, input int hold,
                         input string tag, output int acc_cyc);
    int w, lat;
    logic [127:0] held;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    check({tag, "_in_ready_wait"}, in_ready, 1'b1);
    out_ready = (hold == 0);
    data_in = ct;
    in_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin tick(); lat++; end
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_data"}, data_out, exp_pt);
    held = exp_pt;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_data"}, data_out, held);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    n_blocks++;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k, pt, ct;
    int a1, a2;
    build_sbox();
    rst_n = 1'b0; key = '0; key_valid = 1'b0; data_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_key_ready", key_ready, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 128'h0);
    check("rst_key_loaded", key_loaded, 1'b0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 and B vectors.
    load_key(128'h000102030405060708090a0b0c0d0e0f, "c1");
    decrypt(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0, "c1", a1);
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    load_key(k, "fb");
    decrypt(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0, "fb", a1);

    // Back-pressure for 20 cycles, then two blocks back to back.
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 20, "bp", a1);
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 0, "b2b_a", a1);
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 0, "b2b_b", a2);
    check("b2b_period", 128'(a2 - a1), 128'd12);

    // Key and data offered together in IDLE: key wins, data ignored.
    k = rand128();
    key = k; key_valid = 1'b1; data_in = rand128(); in_valid = 1'b1;
    #1;
    check("simul_in_ready", in_ready, 1'b0);
    tick();
    key_valid = 1'b0; in_valid = 1'b0;
    expect_expansion("simul");
    check("simul_no_out", out_valid, 1'b0);
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 0, "simul", a1);

    // Random keys and blocks.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin k = rand128(); load_key(k, "rnd"); end
      pt = rand128();
      decrypt(m_encrypt(k, pt), pt, int'($urandom_range(0, 3)), "rnd", a1);
    end

    // Reset while ROUND has rcnt = 5 (four round edges after accept).
    pt = rand128();
    data_in = m_encrypt(k, pt); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_data_out", data_out, 128'h0);
    check("mid_rst_key_loaded", key_loaded, 1'b0);
    check("mid_rst_key_ready", key_ready, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    #3;
    rst_n = 1'b1;
    n_blocks = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("post_rst_in_ready", in_ready, 1'b0);
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_key_loaded", key_loaded, 1'b0);
    end
    k = rand128();
    load_key(k, "reload");
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 0, "reload", a1);

`ifdef AES_DEC_PERF_CNT_EN
    for (int i = 0; i < 2; i++) begin
      pt = rand128();
      decrypt(m_encrypt(k, pt), pt, 1, "perf", a1);
    end
    check("perf_count3", 128'(blocks_done), 128'(n_blocks));
    force dut.blocks_done = 32'hFFFF_FFFF;
    #1;
    release dut.blocks_done;
    pt = rand128();
    decrypt(m_encrypt(k, pt), pt, 0, "perf_wrap", a1);
    check("perf_wrap", 128'(blocks_done), 128'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
